// File: rtl/axis_ramp_generator.sv
`default_nettype none
// ============================================================================
// Module      : axis_ramp_generator
// Description : AXI4-Stream programmable ramp source. Emits a sequence that
//               starts at cfg_start and advances by cfg_step on every accepted
//               beat. Three sequence modes are available: wrap, saturate and
//               triangle. Optional tlast framing and an enable-gated run state
//               are also provided. The cfg_* inputs are captured into shadow
//               registers on the IDLE->RUN transition.
// Optional    : `define AXIS_RAMP_WRAP_COUNT_EN adds the 32-bit wrap_count
//               output. It counts wrap events, the first saturation hit of a
//               run, and triangle turnarounds.
// Ports       : aclk, areset (sync, active-high)
//               enable                    - level-sensitive run request
//               cfg_start/step/limit      - ramp configuration
//               cfg_mode                  - 00 wrap, 01 sat, 10 tri, 11 wrap
//               cfg_frame_len             - beats per frame, 0 = no tlast
//               M_AXIS_tready/tvalid/tdata/tlast - master stream
//               busy                      - high while in RUN
//               wrap_count (optional)     - event counter
// Revision    : 1.0 - initial release
// ============================================================================
module axis_ramp_generator #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int COUNTER_WIDTH    = 32,
  parameter int FRAME_LEN_WIDTH  = 16
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        enable,
  input  logic [COUNTER_WIDTH-1:0]    cfg_start,
  input  logic [COUNTER_WIDTH-1:0]    cfg_step,
  input  logic [COUNTER_WIDTH-1:0]    cfg_limit,
  input  logic [1:0]                  cfg_mode,
  input  logic [FRAME_LEN_WIDTH-1:0]  cfg_frame_len,
  input  logic                        M_AXIS_tready,
  output logic                        M_AXIS_tvalid,
  output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
  output logic                        M_AXIS_tlast,
  output logic                        busy
`ifdef AXIS_RAMP_WRAP_COUNT_EN
  ,
  output logic [31:0]                 wrap_count
`endif
);

  localparam int         c_SUM_W     = COUNTER_WIDTH + 1;
  localparam logic [1:0] c_MODE_WRAP = 2'b00;
  localparam logic [1:0] c_MODE_SAT  = 2'b01;
  localparam logic [1:0] c_MODE_TRI  = 2'b10;
  localparam logic       c_DIR_UP    = 1'b0;
  localparam logic       c_DIR_DOWN  = 1'b1;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;
  logic   w_start_run;
  logic   w_hs;

  // Shadow configuration, frozen for the duration of a run
  logic [COUNTER_WIDTH-1:0]   r_start;
  logic [COUNTER_WIDTH-1:0]   r_step;
  logic [COUNTER_WIDTH-1:0]   r_limit;
  logic [1:0]                 r_mode;
  logic [FRAME_LEN_WIDTH-1:0] r_frame_len;

  logic [COUNTER_WIDTH-1:0]   r_value;
  logic                       r_dir;
  logic [FRAME_LEN_WIDTH-1:0] r_beat;

  logic [c_SUM_W-1:0]         w_sum;
  logic [c_SUM_W-1:0]         w_limit_w;
  logic [c_SUM_W-1:0]         w_value_w;
  logic [c_SUM_W-1:0]         w_down_thr;
  logic                       w_degenerate;
  logic [COUNTER_WIDTH-1:0]   w_value_next;
  logic                       w_dir_next;
  logic                       w_tlast;

  // The handshake is taken from registered state only, so tready has no
  // combinational path to tvalid.
  assign w_hs = (r_state == S_RUN) && M_AXIS_tready;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_start_run   = 1'b0;
    M_AXIS_tvalid = 1'b0;
    busy          = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable) begin
          w_state_next = S_RUN;
          w_start_run  = 1'b1;
        end
      end
      S_RUN: begin
        M_AXIS_tvalid = 1'b1;
        busy          = 1'b1;
        // A beat that has been presented must complete before the run stops.
        if (w_hs && !enable) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Next-value arithmetic. All comparisons use one extra bit so that
  // value+step never wraps silently.
  // --------------------------------------------------------------------------
  always_comb begin
    w_sum        = {1'b0, r_value} + {1'b0, r_step};
    w_limit_w    = {1'b0, r_limit};
    w_value_w    = {1'b0, r_value};
    w_down_thr   = {1'b0, r_start} + {1'b0, r_step};
    w_degenerate = (r_step == '0) || (r_start > r_limit);
    w_value_next = r_value;
    w_dir_next   = r_dir;

    if (w_degenerate) begin
      w_value_next = r_start;
      w_dir_next   = c_DIR_UP;
    end else begin
      case (r_mode)
        c_MODE_SAT: begin
          if (w_sum > w_limit_w) begin
            w_value_next = r_limit;
          end else begin
            w_value_next = w_sum[COUNTER_WIDTH-1:0];
          end
        end
        c_MODE_TRI: begin
          if (r_dir == c_DIR_UP) begin
            if (w_sum >= w_limit_w) begin
              w_value_next = r_limit;
              w_dir_next   = c_DIR_DOWN;
            end else begin
              w_value_next = w_sum[COUNTER_WIDTH-1:0];
            end
          end else begin
            if (w_value_w < w_down_thr) begin
              w_value_next = r_start;
              w_dir_next   = c_DIR_UP;
            end else begin
              w_value_next = r_value - r_step;
            end
          end
        end
        default: begin
          // Mode 11 behaves as wrap
          if (w_sum > w_limit_w) begin
            w_value_next = r_start;
          end else begin
            w_value_next = w_sum[COUNTER_WIDTH-1:0];
          end
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_start     <= '0;
      r_step      <= '0;
      r_limit     <= '0;
      r_mode      <= c_MODE_WRAP;
      r_frame_len <= '0;
      r_value     <= '0;
      r_dir       <= c_DIR_UP;
      r_beat      <= '0;
    end else if (w_start_run) begin
      r_start     <= cfg_start;
      r_step      <= cfg_step;
      r_limit     <= cfg_limit;
      r_mode      <= cfg_mode;
      r_frame_len <= cfg_frame_len;
      r_value     <= cfg_start;
      r_dir       <= c_DIR_UP;
      r_beat      <= '0;
    end else if (w_hs) begin
      r_value <= w_value_next;
      r_dir   <= w_dir_next;
      if (w_tlast) begin
        r_beat <= '0;
      end else begin
        r_beat <= r_beat + FRAME_LEN_WIDTH'(1);
      end
    end
  end

  always_comb begin
    w_tlast = (r_state == S_RUN) && (r_frame_len != '0) &&
              (r_beat == (r_frame_len - FRAME_LEN_WIDTH'(1)));
  end

  assign M_AXIS_tlast = w_tlast;

  // --------------------------------------------------------------------------
  // Output width adaptation
  // --------------------------------------------------------------------------
  generate
    if (AXIS_TDATA_WIDTH > COUNTER_WIDTH) begin : g_tdata_zext
      assign M_AXIS_tdata = {{(AXIS_TDATA_WIDTH-COUNTER_WIDTH){1'b0}}, r_value};
    end else if (AXIS_TDATA_WIDTH == COUNTER_WIDTH) begin : g_tdata_same
      assign M_AXIS_tdata = r_value;
    end else begin : g_tdata_trunc
      assign M_AXIS_tdata = r_value[AXIS_TDATA_WIDTH-1:0];
    end
  endgenerate

`ifdef AXIS_RAMP_WRAP_COUNT_EN
  // --------------------------------------------------------------------------
  // Wrap / limit-hit / turnaround event counter
  // --------------------------------------------------------------------------
  logic        r_sat_hit;
  logic [31:0] r_wrap_count;
  logic        w_wrap_event;

  always_comb begin
    w_wrap_event = 1'b0;
    if (!w_degenerate) begin
      case (r_mode)
        c_MODE_SAT: w_wrap_event = (w_sum > w_limit_w) && !r_sat_hit;
        c_MODE_TRI: begin
          if (r_dir == c_DIR_UP) begin
            w_wrap_event = (w_sum >= w_limit_w);
          end else begin
            w_wrap_event = (w_value_w < w_down_thr);
          end
        end
        default:    w_wrap_event = (w_sum > w_limit_w);
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_wrap_count <= '0;
      r_sat_hit    <= 1'b0;
    end else if (w_start_run) begin
      r_wrap_count <= '0;
      r_sat_hit    <= 1'b0;
    end else if (w_hs && w_wrap_event) begin
      r_wrap_count <= r_wrap_count + 32'd1;
      if (r_mode == c_MODE_SAT) begin
        r_sat_hit <= 1'b1;
      end
    end
  end

  assign wrap_count = r_wrap_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axis_ramp_generator.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_ramp_generator
// Description : Directed self-checking bench for axis_ramp_generator. It
//               covers wrap, saturate, triangle, framing under back-pressure,
//               enable drop while stalled, the degenerate start>limit case
//               and a reset applied mid-frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_ramp_generator;

  logic        aclk;
  logic        areset;
  logic        enable;
  logic [31:0] cfg_start;
  logic [31:0] cfg_step;
  logic [31:0] cfg_limit;
  logic [1:0]  cfg_mode;
  logic [15:0] cfg_frame_len;
  logic        tready;
  logic        tvalid;
  logic [31:0] tdata;
  logic        tlast;
  logic        busy;
`ifdef AXIS_RAMP_WRAP_COUNT_EN
  logic [31:0] wrap_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_sat [8];
  logic [31:0] exp_tri [10];
  int          b;

  axis_ramp_generator #(
    .AXIS_TDATA_WIDTH (32),
    .COUNTER_WIDTH    (32),
    .FRAME_LEN_WIDTH  (16)
  ) u_dut (
    .aclk          (aclk),
    .areset        (areset),
    .enable        (enable),
    .cfg_start     (cfg_start),
    .cfg_step      (cfg_step),
    .cfg_limit     (cfg_limit),
    .cfg_mode      (cfg_mode),
    .cfg_frame_len (cfg_frame_len),
    .M_AXIS_tready (tready),
    .M_AXIS_tvalid (tvalid),
    .M_AXIS_tdata  (tdata),
    .M_AXIS_tlast  (tlast),
    .busy          (busy)
`ifdef AXIS_RAMP_WRAP_COUNT_EN
    ,
    .wrap_count    (wrap_count)
`endif
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  initial begin
    exp_sat = '{32'd10, 32'd17, 32'd24, 32'd31, 32'd38, 32'd40, 32'd40, 32'd40};
    exp_tri = '{32'd0, 32'd4, 32'd8, 32'd10, 32'd6, 32'd2, 32'd0, 32'd4, 32'd8, 32'd10};

    areset        = 1'b1;
    enable        = 1'b0;
    cfg_start     = '0;
    cfg_step      = '0;
    cfg_limit     = '0;
    cfg_mode      = 2'b00;
    cfg_frame_len = '0;
    tready        = 1'b0;

    // ---- reset state
    tick();
    tick();
    chk("rst_tvalid", 32'(tvalid), 32'd0);
    chk("rst_tdata",  tdata,       32'd0);
    chk("rst_tlast",  32'(tlast),  32'd0);
    chk("rst_busy",   32'(busy),   32'd0);
    areset = 1'b0;
    tick();
    chk("idle_tvalid", 32'(tvalid), 32'd0);

    // ---- wrap: 0..255 then back to 0,1
    cfg_start = 32'd0; cfg_step = 32'd1; cfg_limit = 32'd255;
    cfg_mode = 2'b00; cfg_frame_len = 16'd0;
    tready = 1'b1;
    enable = 1'b1;
    chk("wrap_pre_tvalid", 32'(tvalid), 32'd0);
    tick();
    chk("wrap_first_tvalid", 32'(tvalid), 32'd1);
    chk("wrap_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 258; i++) begin
      chk("wrap_tdata", tdata, 32'(i % 256));
      chk("wrap_tlast", 32'(tlast), 32'd0);
      tick();
    end
    enable = 1'b0;
    tick();
    chk("wrap_stop_tvalid", 32'(tvalid), 32'd0);
    chk("wrap_stop_busy", 32'(busy), 32'd0);

    // ---- saturate: 10,17,24,31,38,40,40,40
    cfg_start = 32'd10; cfg_step = 32'd7; cfg_limit = 32'd40; cfg_mode = 2'b01;
    enable = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("sat_tdata", tdata, exp_sat[i]);
      tick();
    end
    enable = 1'b0;
    tick();
    chk("sat_stop_tvalid", 32'(tvalid), 32'd0);

    // ---- triangle: 0,4,8,10,6,2,0,4,8,10 with cfg changed mid-run
    cfg_start = 32'd0; cfg_step = 32'd4; cfg_limit = 32'd10; cfg_mode = 2'b10;
    enable = 1'b1;
    tick();
    cfg_start = 32'd99; cfg_step = 32'd1; cfg_limit = 32'd200; cfg_mode = 2'b00;
    for (int i = 0; i < 10; i++) begin
      chk("tri_tdata", tdata, exp_tri[i]);
      tick();
    end
    enable = 1'b0;
    tick();
    chk("tri_stop_tvalid", 32'(tvalid), 32'd0);

    // ---- framing with tready toggling; frame_len=4
    cfg_start = 32'd0; cfg_step = 32'd1; cfg_limit = 32'd1000;
    cfg_mode = 2'b00; cfg_frame_len = 16'd4;
    tready = 1'b0;
    enable = 1'b1;
    tick();
    b = 0;
    for (int c = 0; c < 24; c++) begin
      tready = (c % 2 == 0);
      chk("frm_tvalid", 32'(tvalid), 32'd1);
      chk("frm_tdata",  tdata, 32'(b));
      chk("frm_tlast",  32'(tlast), 32'((b % 4) == 3));
      tick();
      if (tready) b++;
    end

    // ---- drop enable while stalled
    tready = 1'b0;
    enable = 1'b0;
    tick();
    chk("drop_tvalid1", 32'(tvalid), 32'd1);
    chk("drop_tdata1",  tdata, 32'(b));
    chk("drop_busy1",   32'(busy), 32'd1);
    tick();
    chk("drop_tvalid2", 32'(tvalid), 32'd1);
    chk("drop_tdata2",  tdata, 32'(b));
    tready = 1'b1;
    tick();
    chk("drop_tvalid_end", 32'(tvalid), 32'd0);
    chk("drop_busy_end",   32'(busy), 32'd0);

    // ---- degenerate start>limit with frame_len=1
    cfg_start = 32'd50; cfg_step = 32'd3; cfg_limit = 32'd20;
    cfg_mode = 2'b00; cfg_frame_len = 16'd1;
    enable = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("deg_tdata", tdata, 32'd50);
      chk("deg_tlast", 32'(tlast), 32'd1);
      tick();
    end
    enable = 1'b0;
    tick();
    chk("deg_stop_tvalid", 32'(tvalid), 32'd0);

    // ---- reset mid-frame, then restart from cfg_start with beat counter 0
    cfg_start = 32'd5; cfg_step = 32'd1; cfg_limit = 32'd1000;
    cfg_mode = 2'b00; cfg_frame_len = 16'd4;
    enable = 1'b1;
    tick();
    tick();
    tick();
    chk("mid_tdata", tdata, 32'd7);
    areset = 1'b1;
    tick();
    chk("mrst_tvalid", 32'(tvalid), 32'd0);
    chk("mrst_tdata",  tdata, 32'd0);
    chk("mrst_tlast",  32'(tlast), 32'd0);
    chk("mrst_busy",   32'(busy), 32'd0);
    areset = 1'b0;
    tick();
    chk("rerun_tvalid", 32'(tvalid), 32'd1);
    chk("rerun_tdata",  tdata, 32'd5);
    chk("rerun_tlast0", 32'(tlast), 32'd0);
    tick();
    tick();
    tick();
    chk("rerun_tdata3", tdata, 32'd8);
    chk("rerun_tlast3", 32'(tlast), 32'd1);
    tick();
    chk("rerun_tdata4", tdata, 32'd9);
    chk("rerun_tlast4", 32'(tlast), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axis_ramp_generator.md
Name: axis_ramp_generator

Overview:
- Parametrised AXI4-Stream sequence source; successor to the free-running stream counter.
- Emits a programmable ramp: start value, step, limit, three sequence modes, optional tlast framing and an enable-gated run state.
- Sits upstream of DMA/FIFO paths as a test-pattern and sweep source for the signal chain; config driven from register bank.

Parameters:
- AXIS_TDATA_WIDTH, 32, stream data width; counter zero-extended if wider, LSBs taken if narrower.
- COUNTER_WIDTH, 32, width of internal value, start, step, limit.
- FRAME_LEN_WIDTH, 16, width of frame length input and beat counter.

Ports:
- aclk  input  1  system clock, all logic on rising edge.
- areset  input  1  synchronous reset, active-high.
- enable  input  1  run request; level-sensitive.
- cfg_start  input  COUNTER_WIDTH  first value of sequence / wrap target / lower turnaround.
- cfg_step  input  COUNTER_WIDTH  unsigned increment per accepted beat.
- cfg_limit  input  COUNTER_WIDTH  upper bound (inclusive).
- cfg_mode  input  2  00 wrap, 01 saturate, 10 triangle, 11 treated as wrap.
- cfg_frame_len  input  FRAME_LEN_WIDTH  beats per frame; 0 = tlast never asserted.
- M_AXIS_tready  input  1  downstream ready.
- M_AXIS_tvalid  output  1  beat valid.
- M_AXIS_tdata  output  AXIS_TDATA_WIDTH  current value.
- M_AXIS_tlast  output  1  last beat of frame.
- busy  output  1  high while in RUN.

Behaviour:
- Reset (areset=1 at clock edge): state IDLE, tvalid=0, tdata=0, tlast=0, busy=0, value=0, direction=up, beat counter=0. Reset mid-beat discards the beat; no handshake completes on that edge.
- State IDLE: tvalid=0. enable=1 -> RUN on next edge; same edge latches cfg_* into shadow registers, value<=cfg_start, direction<=up, beat counter<=0. cfg_* changes while in RUN are ignored until next IDLE->RUN.
- State RUN: tvalid=1, busy=1, tdata=value. Handshake = tvalid & tready; value and beat counter advance only on handshake. No combinational path tready->tvalid.
- enable=0 in RUN: tvalid held until current beat accepted (AXIS rule), then -> IDLE on that handshake edge. enable=0 with no handshake: stay RUN, data stable.
- Arithmetic: sum computed at COUNTER_WIDTH+1 bits, unsigned, no silent overflow.
- Wrap: sum > limit -> value<=start, else value<=sum.
- Saturate: sum > limit -> value<=limit and holds there (stream continues at limit).
- Triangle up: sum >= limit -> value<=limit, direction<=down. Down: value < start+step (computed wide) -> value<=start, direction<=up; else value<=value-step.
- Degenerate: step=0 or start>limit -> value constant at start for whole run, tlast framing still active.
- tlast: beat counter counts handshakes 0..frame_len-1; tlast=1 combinationally when counter==frame_len-1 and frame_len!=0; counter clears on handshake of tlast beat. frame_len=1 -> tlast on every beat.
- Latency: first valid beat one cycle after enable sampled high in IDLE; thereafter one beat per cycle at tready=1.

Optional Feature:
- Macro AXIS_RAMP_WRAP_COUNT_EN.
- Defined: extra output wrap_count (32 bits): counts wrap events (wrap mode), limit hits (saturate, first hit only per run), turnarounds at either end (triangle); cleared by reset and on IDLE->RUN; wraps modulo 2^32.
- Undefined: port and counter logic absent; remaining behaviour identical.

Test Plan:
- Reset then enable=1, start=0, step=1, limit=255, mode=wrap, tready=1 -> tdata 0,1..255,0,1; first tvalid one cycle after enable.
- start=10, step=7, limit=40, mode=saturate -> 10,17,24,31,38,40,40,...
- start=0, step=4, limit=10, mode=triangle -> 0,4,8,10,6,2,0,4,8,10.
- frame_len=4, tready toggling 1/0 each cycle -> tlast on every 4th accepted beat only; tdata/tvalid stable during tready=0.
- Drop enable while tready=0 -> tvalid stays 1, data unchanged until tready=1, then tvalid=0 next cycle, busy=0.
- Assert areset in RUN mid-frame -> next edge tvalid=0, tdata=0, tlast=0; re-enable restarts from cfg_start with beat counter 0.
